sec_delay_timer: RTL and testbench
==================================

Name: sec_delay_timer

Overview:
- Consumer end of the one-cycle seconds-tick interface.
- Accepts a start request with a delay in whole seconds.
- While running, enables the external tick generator and counts its tick pulses down to zero, then emits a one-cycle done pulse.
- Supports pause, abort and phase re-alignment of the tick generator. Sits between control FSMs (stopwatch/alarm/LED sequencers) and the tick generator.

Parameters:
- CNT_W, 8, width of delay value and remaining-count (max delay 2^CNT_W-1 s).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- i_sec_tick  in  1  one-cycle tick pulse from tick generator; only sampled in RUN
- i_start  in  1  start request; accepted only in IDLE
- i_delay  in  CNT_W  delay in ticks, sampled on accepted start
- i_pause  in  1  level; while high in RUN/PAUSE, counting is frozen
- i_abort  in  1  pulse; cancels an active delay
- o_tick_en  out  1  drive tick generator en; high only in RUN
- o_tick_clr  out  1  one-cycle pulse, OR into tick generator reset to restart its phase
- o_busy  out  1  high in RUN or PAUSE
- o_remain  out  CNT_W  ticks remaining
- o_done  out  1  one-cycle pulse on normal completion
- o_aborted  out  1  one-cycle pulse on abort

Behaviour:
- All outputs registered. Reset, which has priority over everything: state=IDLE, o_remain=0, all 1-bit outputs 0. Reset mid-delay: no done or aborted pulse.
- States: IDLE, RUN, PAUSE (2-bit encoding).
- IDLE:
  - i_start=1 and i_delay!=0: next cycle state=RUN, o_remain=i_delay, o_tick_clr=1 for that one cycle, o_busy=1.
  - i_start=1 and i_delay==0: stay IDLE, o_done=1 next cycle, no tick_clr.
  - Otherwise hold. o_remain keeps its last value (0 after completion or abort).
- RUN, priority per cycle is abort > tick > pause:
  - i_abort: state=IDLE, o_remain=0, o_aborted=1 next cycle. A same-cycle tick is discarded.
  - i_sec_tick with o_remain>1: o_remain-1.
  - i_sec_tick with o_remain==1: o_remain=0, state=IDLE, o_done=1 next cycle.
  - i_pause with no tick: state=PAUSE.
  - i_pause with a tick: the tick is counted, then state=PAUSE. On the final tick, done wins and the state goes to IDLE.
- PAUSE:
  - o_tick_en=0 and ticks are ignored.
  - i_abort behaves as in RUN.
  - i_pause=0: state=RUN; the tick generator resumes from its held phase (no tick_clr).
- i_start while busy: ignored, no restart and no error flag.
- o_tick_en = (state==RUN), registered so it tracks state with no combinational path.
- Latency: done pulse asserts in the cycle after the final tick is sampled. Total delay from the accepted start to o_done is exactly i_delay ticks.
- No wrap-around: decrement never occurs at 0.
- o_done and o_aborted are never high together.

Decomposition:
- Shared package (delay_pkg):
  - state encoding localparams ST_IDLE=0, ST_RUN=1, ST_PAUSE=2;
  - default CNT_W.
- One natural sub-module, delay_down_cnt:
  - loadable CNT_W down-counter with load/dec inputs and a zero-next flag (o_last = value==1);
  - the FSM stays in the top module.
- The tick generator remains a separate instance at the integration level, wired via o_tick_en and o_tick_clr.

Test Plan:
1. Reset, then i_start with i_delay=3 and ticks every 10 cycles. Required: o_tick_clr pulse 1 cycle after start; o_remain 3→2→1→0; o_done exactly one pulse the cycle after the 3rd tick; o_busy falls with it.
2. i_start with i_delay=0. Required: o_done pulse next cycle; o_busy, o_tick_en and o_tick_clr never high.
3. i_delay=5; hold i_pause high after 2 ticks and inject 4 ticks while paused. Required: o_remain stays 3 and o_tick_en=0. Release pause and send 3 ticks. Required: o_done after the 3rd.
4. i_delay=4; i_abort in the same cycle as the 2nd tick. Required: o_remain=0, o_aborted pulse, no o_done, state IDLE.
5. i_delay=2; second i_start with i_delay=9 mid-run. Required: ignored, o_remain continues 1→0, done after 2 ticks total.
6. i_delay=6; reset asserted after 1 tick. Required: all outputs 0 next cycle, no done or aborted pulse; a fresh start with i_delay=1 then completes normally.

Source files
------------

// File: rtl/delay_pkg.sv
// Shared definitions for the seconds-delay timer: state encoding and default width.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package delay_pkg;

  localparam int CNT_W_DEF = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    RUN   = ST_RUN,
    PAUSE = ST_PAUSE
  } state_t;

endpackage

// File: rtl/delay_down_cnt.sv
// Loadable down-counter holding the remaining tick count, with a one-left flag.
// Latency: value updates one cycle after clr/load/dec; o_last is combinational from value.
// Backpressure: none; decrement is suppressed at zero so the count never wraps.
// Ports: clk, reset (sync, active-high), i_clr (force 0), i_load/i_load_val (load),
//        i_dec (count down one), o_value (current count), o_last (value == 1).
module delay_down_cnt
  import delay_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_value,
  output logic             o_last
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      o_value <= '0;
    end else if (i_load) begin
      o_value <= i_load_val;
    end else if (i_dec && (o_value != '0)) begin
      o_value <= o_value - ONE;
    end
  end

  assign o_last = (o_value == ONE);

endmodule

// File: rtl/sec_delay_timer.sv
// Counts a start-supplied number of seconds ticks, with pause/abort and tick-phase restart.
// Latency: busy/tick_clr one cycle after accepted start; done one cycle after the final tick.
// Backpressure: none; starts while busy are dropped, ticks outside RUN are ignored.
// Ports: clk, reset (sync, active-high); i_sec_tick, i_start, i_delay, i_pause, i_abort in;
//        o_tick_en, o_tick_clr (to tick generator), o_busy, o_remain, o_done, o_aborted out.
module sec_delay_timer
  import delay_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_sec_tick,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_delay,
  input  logic             i_pause,
  input  logic             i_abort,
  output logic             o_tick_en,
  output logic             o_tick_clr,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_remain,
  output logic             o_done,
  output logic             o_aborted
);

  state_t state;
  logic   active;
  logic   start_ok;
  logic   tick_run;
  logic   cnt_last;

  assign active   = (state == RUN) || (state == PAUSE);
  assign start_ok = (state == IDLE) && i_start && (i_delay != '0);
  // Abort outranks a same-cycle tick, so the tick is only counted when not aborting.
  assign tick_run = (state == RUN) && i_sec_tick && !i_abort;

  delay_down_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .i_clr      (active && i_abort),
    .i_load     (start_ok),
    .i_load_val (i_delay),
    .i_dec      (tick_run),
    .o_value    (o_remain),
    .o_last     (cnt_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      o_tick_en  <= 1'b0;
      o_tick_clr <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_aborted  <= 1'b0;
    end else begin
      o_tick_clr <= 1'b0;
      o_done     <= 1'b0;
      o_aborted  <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            if (i_delay != '0) begin
              state      <= RUN;
              o_tick_en  <= 1'b1;
              o_tick_clr <= 1'b1;
              o_busy     <= 1'b1;
            end else begin
              // Zero delay completes immediately without touching the tick generator.
              o_done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (i_abort) begin
            state     <= IDLE;
            o_tick_en <= 1'b0;
            o_busy    <= 1'b0;
            o_aborted <= 1'b1;
          end else if (i_sec_tick && cnt_last) begin
            // Final tick: completion wins over a concurrent pause.
            state     <= IDLE;
            o_tick_en <= 1'b0;
            o_busy    <= 1'b0;
            o_done    <= 1'b1;
          end else if (i_pause) begin
            state     <= PAUSE;
            o_tick_en <= 1'b0;
          end
        end
        PAUSE: begin
          if (i_abort) begin
            state     <= IDLE;
            o_busy    <= 1'b0;
            o_aborted <= 1'b1;
          end else if (!i_pause) begin
            // Resume from the held generator phase, so no tick_clr here.
            state     <= RUN;
            o_tick_en <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          o_tick_en <= 1'b0;
          o_busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sec_delay_timer.sv
// Directed bench for sec_delay_timer: each step drives inputs and queues the expected
// registered outputs for the following cycle; the queue is popped and compared after the edge.
// Ports: drives every DUT input, observes every DUT output.
module tb_sec_delay_timer;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             i_sec_tick = 1'b0;
  logic             i_start = 1'b0;
  logic [CNT_W-1:0] i_delay = '0;
  logic             i_pause = 1'b0;
  logic             i_abort = 1'b0;
  logic             o_tick_en;
  logic             o_tick_clr;
  logic             o_busy;
  logic [CNT_W-1:0] o_remain;
  logic             o_done;
  logic             o_aborted;

  typedef struct packed {
    logic             en;
    logic             clr;
    logic             busy;
    logic [CNT_W-1:0] remain;
    logic             done;
    logic             ab;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   done_cnt = 0;
  int   ab_cnt = 0;

  always #5 clk = ~clk;

  sec_delay_timer #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_sec_tick (i_sec_tick),
    .i_start    (i_start),
    .i_delay    (i_delay),
    .i_pause    (i_pause),
    .i_abort    (i_abort),
    .o_tick_en  (o_tick_en),
    .o_tick_clr (o_tick_clr),
    .o_busy     (o_busy),
    .o_remain   (o_remain),
    .o_done     (o_done),
    .o_aborted  (o_aborted)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    assert (act === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  // Drive one cycle of inputs, queue expectations, then compare after the edge.
  task automatic step(input logic st, input logic [CNT_W-1:0] dly, input logic tk,
                      input logic ps, input logic ab,
                      input logic e_en, input logic e_clr, input logic e_busy,
                      input logic [CNT_W-1:0] e_rem, input logic e_done, input logic e_ab);
    exp_t e;
    exp_t got;
    @(negedge clk);
    i_start = st; i_delay = dly; i_sec_tick = tk; i_pause = ps; i_abort = ab;
    e.en = e_en; e.clr = e_clr; e.busy = e_busy; e.remain = e_rem; e.done = e_done; e.ab = e_ab;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (o_done) done_cnt++;
    if (o_aborted) ab_cnt++;
    got = exp_q.pop_front();
    chk("tick_en", {31'd0, o_tick_en}, {31'd0, got.en});
    chk("tick_clr", {31'd0, o_tick_clr}, {31'd0, got.clr});
    chk("busy", {31'd0, o_busy}, {31'd0, got.busy});
    chk("remain", {24'd0, o_remain}, {24'd0, got.remain});
    chk("done", {31'd0, o_done}, {31'd0, got.done});
    chk("aborted", {31'd0, o_aborted}, {31'd0, got.ab});
  endtask

  // n quiet cycles with steady expectations (no pulses).
  task automatic hold(input int n, input logic ps, input logic e_en, input logic e_busy,
                      input logic [CNT_W-1:0] e_rem);
    for (int k = 0; k < n; k++) step(0, 0, 0, ps, 0, e_en, 0, e_busy, e_rem, 0, 0);
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    hold(2, 0, 0, 0, 0);

    // 1: delay 3, ticks every 10 cycles
    step(1, 3, 0, 0, 0, 1, 1, 1, 3, 0, 0);
    hold(9, 0, 1, 1, 3);
    step(0, 0, 1, 0, 0, 1, 0, 1, 2, 0, 0);
    hold(9, 0, 1, 1, 2);
    step(0, 0, 1, 0, 0, 1, 0, 1, 1, 0, 0);
    hold(9, 0, 1, 1, 1);
    step(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    hold(3, 0, 0, 0, 0);

    // 2: zero delay completes at once, never busy
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    hold(3, 0, 0, 0, 0);

    // 3: delay 5, second tick arrives with pause raised, ticks ignored while paused
    step(1, 5, 0, 0, 0, 1, 1, 1, 5, 0, 0);
    hold(2, 0, 1, 1, 5);
    step(0, 0, 1, 0, 0, 1, 0, 1, 4, 0, 0);
    hold(2, 0, 1, 1, 4);
    step(0, 0, 1, 1, 0, 0, 0, 1, 3, 0, 0);
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 1, 1, 0, 0, 0, 1, 3, 0, 0);
      hold(2, 1, 0, 1, 3);
    end
    step(0, 0, 0, 0, 0, 1, 0, 1, 3, 0, 0);
    hold(2, 0, 1, 1, 3);
    step(0, 0, 1, 0, 0, 1, 0, 1, 2, 0, 0);
    hold(2, 0, 1, 1, 2);
    step(0, 0, 1, 0, 0, 1, 0, 1, 1, 0, 0);
    hold(2, 0, 1, 1, 1);
    step(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    hold(2, 0, 0, 0, 0);

    // 4: delay 4, abort together with second tick
    step(1, 4, 0, 0, 0, 1, 1, 1, 4, 0, 0);
    step(0, 0, 1, 0, 0, 1, 0, 1, 3, 0, 0);
    hold(2, 0, 1, 1, 3);
    step(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1);
    hold(3, 0, 0, 0, 0);

    // 5: delay 2, restart attempt with 9 while running is ignored
    step(1, 2, 0, 0, 0, 1, 1, 1, 2, 0, 0);
    step(0, 0, 1, 0, 0, 1, 0, 1, 1, 0, 0);
    step(1, 9, 0, 0, 0, 1, 0, 1, 1, 0, 0);
    hold(2, 0, 1, 1, 1);
    step(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    hold(2, 0, 0, 0, 0);

    // Abort while paused
    step(1, 3, 0, 0, 0, 1, 1, 1, 3, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 1, 3, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1);
    hold(2, 0, 0, 0, 0);

    // 6: delay 6, reset after one tick, then a fresh delay of 1
    step(1, 6, 0, 0, 0, 1, 1, 1, 6, 0, 0);
    step(0, 0, 1, 0, 0, 1, 0, 1, 5, 0, 0);
    reset = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    hold(3, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 1, 1, 1, 1, 0, 0);
    hold(2, 0, 1, 1, 1);
    step(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    hold(2, 0, 0, 0, 0);

    // Pulse totals across the run: done in tests 1,2,3,5,6b; aborted in 4 and pause-abort
    chk("done_total", done_cnt, 5);
    chk("aborted_total", ab_cnt, 2);
    chk("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
